key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//   Conditions one raw DE10-Nano push-button (KEY, active-low, mechanically bouncy) into
//   clean level and single-cycle event outputs on the 50 MHz fabric clock.
//   Sits directly upstream of the LED blink stage and drives its rate-select and enable controls.
//   Provides press, release and long-press events plus a wrapping press counter.
// PARAMETERS
//   CLK_HZ       50_000_000  fabric clock frequency in Hz
//   DEBOUNCE_MS  20          stable time in ms required to accept a level change
//   LONG_MS      1000        hold time in ms, measured after press commit, that fires long_pulse
//   ACTIVE_LOW   1           1: key_in=0 means pressed; 0: key_in=1 means pressed
//   CNT_W        8           width of press_count
// PORTS
//   clk            in   1      50 MHz clock
//   rst_n          in   1      asynchronous active-low reset
//   key_in         in   1      raw asynchronous button pin
//   key_level      out  1      debounced level, 1 = pressed
//   press_pulse    out  1      1-cycle strobe when a press commits
//   release_pulse  out  1      1-cycle strobe when a release commits
//   long_pulse     out  1      1-cycle strobe when hold time reaches LONG_MS
//   press_count    out  CNT_W  number of committed presses, modulo 2**CNT_W
// BEHAVIOUR
//   - Constants: DEB_CYC = CLK_HZ/1000*DEBOUNCE_MS and LONG_CYC = CLK_HZ/1000*LONG_MS.
//     Counter width is $clog2(max(DEB_CYC,LONG_CYC)+1); elaboration error if DEB_CYC < 1.
//   - Reset (async assert, sync release): all outputs 0, state UP, counters 0.
//     Synchroniser flops reset to the released pin level (1 if ACTIVE_LOW).
//   - Input path: 2-flop synchroniser, then polarity normalise to key_s (1 = pressed).
//   - FSM states UP, WAIT_DN, DOWN, WAIT_UP:
//       UP:      key_s=1 -> WAIT_DN, cnt=1.
//       WAIT_DN: key_s=0 -> UP (bounce, cnt cleared).
//                key_s=1 && cnt==DEB_CYC -> DOWN; press_pulse=1; press_count++; hold=0.
//                Otherwise cnt++.
//       DOWN:    hold++ saturating at LONG_CYC; long_pulse=1 on the cycle hold reaches LONG_CYC.
//                Fires once per press, never repeats.
//                key_s=0 -> WAIT_UP, cnt=1; hold frozen.
//       WAIT_UP: key_s=1 -> DOWN (bounce; hold resumes, long_pulse may still fire).
//                key_s=0 && cnt==DEB_CYC -> UP; release_pulse=1.
//   - key_level=1 in DOWN and WAIT_UP, otherwise 0. It changes in the same cycle as the
//     commit pulse.
//   - Latency: a clean edge on key_in yields its pulse in the (DEB_CYC+3)th cycle after the
//     first sampling edge (2 cycles sync + DEB_CYC count + 1 commit).
//   - Outputs are registered; at most one of press/release/long is high in any cycle.
//   - press_count wraps 2**CNT_W-1 -> 0 silently.
//   - Glitches shorter than DEB_CYC cycles never produce events.
//   - Reset asserted mid-press: all state clears. If the key is still held at reset release,
//     a fresh press is detected after full debounce.
// STRUCTURE
//   - key_debounce_pkg: state enum typedef (UP, WAIT_DN, DOWN, WAIT_UP) and a function
//     ms_to_cycles(clk_hz, ms).
//   - Sub-module sync_2ff: parameter RESET_VAL, async active-low reset. Reused by later
//     blocks for the switches.
//   - Top level holds the FSM, the debounce counter, the hold counter and press_count.
// TESTING  (CLK_HZ=1000, DEBOUNCE_MS=4 -> DEB_CYC=4, LONG_MS=20 -> LONG_CYC=20, ACTIVE_LOW=1)
//   - Reset: rst_n=0 with key_in=1 -> all outputs 0 and press_count=0, asynchronously with no clk edge.
//   - Clean press: key_in 1->0 held -> press_pulse high exactly 7 cycles after the first
//     sampling edge, for 1 cycle; key_level=1; press_count=1.
//   - Bounce: key_in low 3 cycles, high 1 cycle, repeated 5 times -> no pulses, key_level stays 0.
//     A following stable low -> exactly 1 press_pulse.
//   - Long hold: key_in low for 40 cycles -> 1 press_pulse, then 1 long_pulse 20 cycles later,
//     no further long_pulse. Release -> 1 release_pulse 7 cycles after key_in rises.
//   - Wrap: 256 clean presses -> press_count returns to 0. Each press gives exactly one
//     press_pulse and one release_pulse.
//   - Reset mid-hold: assert rst_n while in DOWN, key_in kept low -> outputs clear.
//     After release of reset, a new press_pulse follows once the key has been stable low for
//     DEB_CYC cycles after the synchroniser.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer and its neighbours.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } deb_state_e;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous pin; resets to the pin's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage metastability filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/key_debounce.sv
// Debounces one bouncy push-button into a clean level, press/release/long-press
// strobes and a wrapping press counter.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_in,
  output logic             key_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int MAX_CYC  = (DEB_CYC > LONG_CYC) ? DEB_CYC : LONG_CYC;
  localparam int CW       = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DEB_LIM  = CW'(DEB_CYC);
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic SYNC_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  if (DEB_CYC < 1) begin : g_deb_check
    $error("key_debounce: debounce interval must be at least one clock cycle");
  end

  logic             key_sync_s;
  logic             key_s;
  deb_state_e       state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [CW-1:0]    hold_r, hold_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             level_r, level_nxt_s;
  logic             press_r, press_nxt_s;
  logic             release_r, release_nxt_s;
  logic             long_r, long_nxt_s;

  sync_2ff #(
    .RESET_VAL (SYNC_IDLE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_sync_s)
  );

  assign key_s = ACTIVE_LOW ? ~key_sync_s : key_sync_s;

  // Next-state, counter and strobe decode for the debounce FSM.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    hold_nxt_s    = hold_r;
    count_nxt_s   = count_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    case (state_r)
      UP: begin
        if (key_s) begin
          state_nxt_s = WAIT_DN;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          cnt_nxt_s   = '0;
        end
      end
      WAIT_DN: begin
        if (!key_s) begin
          state_nxt_s = UP;
          cnt_nxt_s   = '0;
        end else if (cnt_r == DEB_LIM) begin
          state_nxt_s = DOWN;
          cnt_nxt_s   = '0;
          hold_nxt_s  = '0;
          press_nxt_s = 1'b1;
          count_nxt_s = count_r + CNT_W'(1'b1);
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      DOWN: begin
        // Hold time only advances while the key reads pressed; it saturates so the strobe never repeats.
        if (!key_s) begin
          state_nxt_s = WAIT_UP;
          cnt_nxt_s   = CNT_ONE;
        end else if (hold_r != LONG_LIM) begin
          hold_nxt_s  = hold_r + CNT_ONE;
          long_nxt_s  = ((hold_r + CNT_ONE) == LONG_LIM);
        end else begin
          hold_nxt_s  = hold_r;
        end
      end
      WAIT_UP: begin
        if (key_s) begin
          state_nxt_s   = DOWN;
          cnt_nxt_s     = '0;
        end else if (cnt_r == DEB_LIM) begin
          state_nxt_s   = UP;
          cnt_nxt_s     = '0;
          release_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s     = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = UP;
        cnt_nxt_s   = '0;
        hold_nxt_s  = '0;
      end
    endcase
    level_nxt_s = (state_nxt_s == DOWN) || (state_nxt_s == WAIT_UP);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= UP;
      cnt_r     <= '0;
      hold_r    <= '0;
      count_r   <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      hold_r    <= hold_nxt_s;
      count_r   <= count_nxt_s;
      level_r   <= level_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      long_r    <= long_nxt_s;
    end
  end

  assign key_level     = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign long_pulse    = long_r;
  assign press_count   = count_r;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: segment table plus scoreboard of timed events.
module tb_key_debounce;

  typedef enum int {EV_NONE, EV_PRESS, EV_REL, EV_LONG} ev_e;

  typedef struct {
    logic key;
    int   n;
    ev_e  ev;
    logic lvl;
  } seg_t;

  typedef struct {
    ev_e        ev;
    int         cyc;
    logic [7:0] cnt;
    logic       lvl;
  } exp_t;

  localparam int LAT      = 7;   // 2 sync + DEB_CYC + 1 commit
  localparam int LONG_CYC = 20;

  logic       clk;
  logic       rst_n;
  logic       key_in;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int         checks;
  int         errors;
  int         cyc;
  logic [7:0] exp_count;
  exp_t       sb_q[$];
  seg_t       tbl[$];

  key_debounce #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (20),
    .ACTIVE_LOW  (1'b1),
    .CNT_W       (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input ev_e ev, input int at, input logic lvl);
    exp_t e;
    e.ev  = ev;
    e.cyc = at;
    e.cnt = exp_count;
    e.lvl = lvl;
    sb_q.push_back(e);
  endtask

  // Drive one segment starting at a negedge; schedule the event it should cause.
  task automatic run_seg(input seg_t s);
    int base;
    key_in = s.key;
    base   = cyc;
    if (s.ev == EV_PRESS) begin
      exp_count = exp_count + 8'd1;
      push(EV_PRESS, base + LAT, 1'b1);
    end else if (s.ev == EV_REL) begin
      push(EV_REL, base + LAT, 1'b0);
    end
    repeat (s.n) @(negedge clk);
    chk("seg_level", int'(key_level), int'(s.lvl));
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    ev_e  got;
    exp_t e;
    if (press_pulse || release_pulse || long_pulse) begin
      got = press_pulse ? EV_PRESS : (release_pulse ? EV_REL : EV_LONG);
      chk("pulse_exclusive", int'(press_pulse) + int'(release_pulse) + int'(long_pulse), 1);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %s at cycle %0d, none pending", got.name(), cyc);
      end else begin
        e = sb_q.pop_front();
        if (got != e.ev || cyc != e.cyc) begin
          errors++;
          $display("FAIL event: got %s at cycle %0d expected %s at cycle %0d",
                   got.name(), cyc, e.ev.name(), e.cyc);
        end
        chk("event_count", int'(press_count), int'(e.cnt));
        chk("event_level", int'(key_level), int'(e.lvl));
      end
    end
  end

  initial begin
    int   base;
    logic [7:0] start_cnt;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    exp_count = 8'd0;
    rst_n     = 1'b1;
    key_in    = 1'b1;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_level", int'(key_level), 0);
    chk("reset_count", int'(press_count), 0);
    chk("reset_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press/release, bounce train, minimal-length press, high glitch while held.
    tbl.push_back('{1'b0, 10, EV_PRESS, 1'b1});
    tbl.push_back('{1'b1, 10, EV_REL,   1'b0});
    for (int i = 0; i < 5; i++) begin
      tbl.push_back('{1'b0, 3, EV_NONE, 1'b0});
      tbl.push_back('{1'b1, 1, EV_NONE, 1'b0});
    end
    tbl.push_back('{1'b0, 10, EV_PRESS, 1'b1});
    tbl.push_back('{1'b1, 10, EV_REL,   1'b0});
    tbl.push_back('{1'b0, 5,  EV_PRESS, 1'b0});
    tbl.push_back('{1'b1, 10, EV_REL,   1'b0});
    tbl.push_back('{1'b0, 10, EV_PRESS, 1'b1});
    tbl.push_back('{1'b1, 3,  EV_NONE,  1'b1});
    tbl.push_back('{1'b0, 10, EV_NONE,  1'b1});
    tbl.push_back('{1'b1, 10, EV_REL,   1'b0});
    for (int i = 0; i < tbl.size(); i++) run_seg(tbl[i]);
    repeat (10) @(negedge clk);
    chk("table_drain", sb_q.size(), 0);
    chk("table_count", int'(press_count), 4);

    // Long hold: one long strobe LONG_CYC after the press, never repeated.
    key_in    = 1'b0;
    base      = cyc;
    exp_count = exp_count + 8'd1;
    push(EV_PRESS, base + LAT, 1'b1);
    push(EV_LONG, base + LAT + LONG_CYC, 1'b1);
    repeat (40) @(negedge clk);
    key_in = 1'b1;
    push(EV_REL, cyc + LAT, 1'b0);
    repeat (12) @(negedge clk);
    chk("long_drain", sb_q.size(), 0);

    // Reset while held: outputs clear at once, then a fresh debounced press.
    key_in    = 1'b0;
    exp_count = exp_count + 8'd1;
    push(EV_PRESS, cyc + LAT, 1'b1);
    repeat (12) @(negedge clk);
    chk("hold_before_reset", int'(key_level), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_level", int'(key_level), 0);
    chk("midreset_count", int'(press_count), 0);
    chk("midreset_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
    exp_count = 8'd0;
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    exp_count = 8'd1;
    push(EV_PRESS, cyc + LAT, 1'b1);
    repeat (10) @(negedge clk);
    key_in = 1'b1;
    push(EV_REL, cyc + LAT, 1'b0);
    repeat (10) @(negedge clk);
    chk("midreset_drain", sb_q.size(), 0);

    // 256 presses bring the counter back to where it started.
    start_cnt = press_count;
    for (int i = 0; i < 256; i++) begin
      run_seg('{1'b0, 8, EV_PRESS, 1'b1});
      run_seg('{1'b1, 8, EV_REL,   1'b0});
    end
    repeat (10) @(negedge clk);
    chk("wrap_count", int'(press_count), int'(start_cnt));
    chk("final_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
